// File: rtl/ad_serial_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad_serial_capture
// Brief    : Periodic 8-bit serial ADC capture with registered sample and strobe.
// Revision : 1.0 - initial release
// ============================================================================
module ad_serial_capture #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       ad_cs_n,
    output logic       ad_sclk,
    input  logic       ad_dout,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       busy,
    output logic       overrun
);

    localparam int c_ph_w = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int c_tm_w = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(2 * CLK_DIV - 1);
    localparam logic [c_ph_w-1:0] c_ph_half = c_ph_w'(CLK_DIV);
    localparam logic [c_tm_w-1:0] c_tm_last = c_tm_w'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [c_ph_w-1:0] r_ph;
    logic [c_ph_w-1:0] w_ph_nx;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nx;
    logic [c_tm_w-1:0] r_timer;
    logic [7:0]        r_shift;
    logic [7:0]        r_sample;
    logic              r_cs_n;
    logic              r_sclk;
    logic              r_valid;
    logic              r_busy;
    logic              r_overrun;

    logic              w_start;
    logic              w_capture;
    logic              w_cs_n_nx;
    logic              w_sclk_nx;

    assign w_start = enable && (r_timer == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ph    <= '0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_ph    <= w_ph_nx;
            r_bit   <= w_bit_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ph_nx    = r_ph;
        w_bit_nx   = r_bit;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_SETUP;
                    w_ph_nx    = '0;
                end
            end
            S_SETUP: begin
                if (r_ph == c_ph_last) begin
                    w_state_nx = S_SHIFT;
                    w_ph_nx    = '0;
                    w_bit_nx   = 3'd7;
                end else begin
                    w_ph_nx = r_ph + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_ph == c_ph_last) begin
                    w_ph_nx = '0;
                    if (r_bit == 3'd0) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_bit_nx = r_bit - 3'd1;
                    end
                end else begin
                    w_ph_nx = r_ph + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the pins come straight off flops
        w_cs_n_nx = !((w_state_nx == S_SETUP) || (w_state_nx == S_SHIFT));
        w_sclk_nx = (w_state_nx == S_SHIFT) && (w_ph_nx >= c_ph_half);
        w_capture = (w_state_nx == S_SHIFT) && (w_ph_nx == c_ph_half);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (!enable) begin
            r_timer <= '0;
        end else if (r_timer == c_tm_last) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_shift   <= 8'h00;
            r_sample  <= 8'h00;
        end else begin
            r_cs_n  <= w_cs_n_nx;
            r_sclk  <= w_sclk_nx;
            r_valid <= (w_state_nx == S_DONE);
            r_busy  <= (w_state_nx != S_IDLE);
            if (w_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_capture) begin
                r_shift <= {r_shift[6:0], ad_dout};
            end
            if (w_state_nx == S_DONE) begin
                r_sample <= r_shift;
            end
        end
    end

    assign ad_cs_n      = r_cs_n;
    assign ad_sclk      = r_sclk;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ad_serial_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ad_serial_capture
// Brief    : Directed bench for ad_serial_capture with behavioural serial ADCs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_serial_capture;

    logic clk = 1'b0;
    logic reset;
    logic en0, en1, en2;

    logic       cs0, sclk0, v0, busy0, ovr0;
    logic       cs1, sclk1, v1, busy1, ovr1;
    logic       cs2, sclk2, v2, busy2, ovr2;
    logic [7:0] smp0, smp1, smp2;
    logic       dout0 = 1'b0;
    logic       dout1 = 1'b0;
    logic       dout2 = 1'b0;
    logic [7:0] sh0, sh1, sh2;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ad_serial_capture #(.CLK_DIV(4), .SAMPLE_PERIOD(256)) u_dflt (
        .clk(clk), .reset(reset), .enable(en0), .ad_cs_n(cs0), .ad_sclk(sclk0),
        .ad_dout(dout0), .sample(smp0), .sample_valid(v0), .busy(busy0), .overrun(ovr0));

    ad_serial_capture #(.CLK_DIV(4), .SAMPLE_PERIOD(50)) u_ovr (
        .clk(clk), .reset(reset), .enable(en1), .ad_cs_n(cs1), .ad_sclk(sclk1),
        .ad_dout(dout1), .sample(smp1), .sample_valid(v1), .busy(busy1), .overrun(ovr1));

    ad_serial_capture #(.CLK_DIV(1), .SAMPLE_PERIOD(256)) u_fast (
        .clk(clk), .reset(reset), .enable(en2), .ad_cs_n(cs2), .ad_sclk(sclk2),
        .ad_dout(dout2), .sample(smp2), .sample_valid(v2), .busy(busy2), .overrun(ovr2));

    // ADC models: MSB presented on CS fall, next bit on each SCLK fall
    always @(negedge cs0) begin
        sh0 = (q0.size() > 0) ? q0.pop_front() : 8'h00;
        dout0 = sh0[7];
    end
    always @(negedge sclk0) if (!cs0) begin
        sh0 = {sh0[6:0], 1'b0};
        dout0 = sh0[7];
    end
    always @(negedge cs1) begin
        sh1 = (q1.size() > 0) ? q1.pop_front() : 8'h00;
        dout1 = sh1[7];
    end
    always @(negedge sclk1) if (!cs1) begin
        sh1 = {sh1[6:0], 1'b0};
        dout1 = sh1[7];
    end
    always @(negedge cs2) begin
        sh2 = (q2.size() > 0) ? q2.pop_front() : 8'h00;
        dout2 = sh2[7];
    end
    always @(negedge sclk2) if (!cs2) begin
        sh2 = {sh2[6:0], 1'b0};
        dout2 = sh2[7];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt, rise, nv, csact;
        int vc[3];
        logic [7:0] vs[3];
        int rc[2];
        logic ps;

        reset = 1'b1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs0, 1);
        check("rst_sclk", sclk0, 0);
        check("rst_sample", smp0, 8'h00);
        check("rst_valid", v0, 0);
        check("rst_busy", busy0, 0);
        check("rst_overrun", ovr0, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single conversion of 0xA5
        q0.push_back(8'hA5);
        en0 = 1'b1;
        vcnt = 0; rise = -1; ps = sclk0;
        for (int c = 1; c <= 74; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("t1_cs_low", cs0, 0);
                check("t1_busy_high", busy0, 1);
            end
            if (sclk0 && !ps && rise < 0) rise = c;
            ps = sclk0;
            if (v0) vcnt++;
            if (c == 73) begin
                check("t1_valid", v0, 1);
                check("t1_sample", smp0, 8'hA5);
            end
            if (c == 74) begin
                check("t1_busy_low", busy0, 0);
                check("t1_cs_high", cs0, 1);
            end
        end
        check("t1_first_rise", rise, 13);
        check("t1_valid_count", vcnt, 1);
        en0 = 1'b0;
        pulse_reset();

        // Back-to-back periodic conversions
        q0.push_back(8'h00); q0.push_back(8'hFF); q0.push_back(8'h3C);
        en0 = 1'b1;
        nv = 0; rise = 0; ps = sclk0;
        for (int c = 1; c <= 590; c++) begin
            @(negedge clk);
            if (sclk0 && !ps) rise++;
            ps = sclk0;
            if (v0) begin
                if (nv < 3) begin
                    vc[nv] = c;
                    vs[nv] = smp0;
                end
                nv++;
            end
        end
        check("t2_valid_count", nv, 3);
        check("t2_vcyc0", vc[0], 73);
        check("t2_vcyc1", vc[1], 329);
        check("t2_vcyc2", vc[2], 585);
        check("t2_samp0", vs[0], 8'h00);
        check("t2_samp1", vs[1], 8'hFF);
        check("t2_samp2", vs[2], 8'h3C);
        check("t2_sclk_rises", rise, 24);
        check("t2_overrun", ovr0, 0);
        en0 = 1'b0;
        pulse_reset();

        // Reset during SHIFT aborts the conversion
        q0.push_back(8'h66); q0.push_back(8'h9C);
        en0 = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t3_cs_n", cs0, 1);
        check("t3_sclk", sclk0, 0);
        check("t3_busy", busy0, 0);
        check("t3_valid", v0, 0);
        check("t3_sample", smp0, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        for (int c = 1; c <= 74; c++) begin
            @(negedge clk);
            if (v0) vcnt++;
            if (c == 73) check("t3_resume_sample", smp0, 8'h9C);
        end
        check("t3_valid_count", vcnt, 1);
        en0 = 1'b0;
        pulse_reset();

        // Enable dropped mid-conversion
        q0.push_back(8'h4B);
        en0 = 1'b1;
        vcnt = 0; csact = 0; vc[0] = -1;
        for (int c = 1; c <= 1074; c++) begin
            @(negedge clk);
            if (c == 20) en0 = 1'b0;
            if (v0) begin
                vcnt++;
                vc[0] = c;
                vs[0] = smp0;
            end
            if (c > 74 && !cs0) csact++;
        end
        check("t5_valid_cycle", vc[0], 73);
        check("t5_sample", vs[0], 8'h4B);
        check("t5_valid_count", vcnt, 1);
        check("t5_cs_activity", csact, 0);
        pulse_reset();

        // Short period forces dropped requests
        q1.push_back(8'h5A); q1.push_back(8'hC3); q1.push_back(8'h17);
        en1 = 1'b1;
        nv = 0;
        for (int c = 1; c <= 280; c++) begin
            @(negedge clk);
            if (c == 50) check("t4_ovr_before", ovr1, 0);
            if (c == 51) check("t4_ovr_set", ovr1, 1);
            if (v1) begin
                if (nv < 3) begin
                    vc[nv] = c;
                    vs[nv] = smp1;
                end
                nv++;
            end
        end
        check("t4_valid_count", nv, 3);
        check("t4_vcyc0", vc[0], 73);
        check("t4_vcyc1", vc[1], 173);
        check("t4_vcyc2", vc[2], 273);
        check("t4_samp0", vs[0], 8'h5A);
        check("t4_samp1", vs[1], 8'hC3);
        check("t4_samp2", vs[2], 8'h17);
        en1 = 1'b0;
        repeat (100) @(negedge clk);
        check("t4_ovr_sticky", ovr1, 1);
        pulse_reset();
        check("t4_ovr_cleared", ovr1, 0);

        // Fastest serial clock
        q2.push_back(8'h81);
        en2 = 1'b1;
        nv = 0; vcnt = 0; vc[0] = -1; ps = sclk2;
        rc[0] = -1; rc[1] = -1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (sclk2 && !ps) begin
                if (nv < 2) rc[nv] = c;
                nv++;
            end
            ps = sclk2;
            if (v2) begin
                vcnt++;
                vc[0] = c;
                vs[0] = smp2;
            end
        end
        check("t6_rise0", rc[0], 4);
        check("t6_rise1", rc[1], 6);
        check("t6_rises", nv, 8);
        check("t6_valid_cycle", vc[0], 19);
        check("t6_sample", vs[0], 8'h81);
        check("t6_valid_count", vcnt, 1);
        en2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad_serial_capture.md
# ad_serial_capture

Serial ADC front end that sits directly upstream of the PCM/Hamming/FSK transmit chain. It periodically runs a conversion on an 8-bit serial-output ADC, generating chip-select and serial clock and shifting in the result MSB first. Each captured sample is presented as a registered byte with a one-cycle valid strobe, and drives the chain's 8-bit `datain`. Conversion rate and serial clock rate are set by parameters.

## Interface

- CLK_DIV, 4: `clk` cycles per serial-clock half period; legal range is 1 or more.
- SAMPLE_PERIOD, 256: `clk` cycles between conversion starts; legal range is 2 or more.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; while high, conversions start periodically.
- ad_cs_n  out  1  ADC chip select, active low, registered.
- ad_sclk  out  1  ADC serial clock, registered.
- ad_dout  in  1  ADC serial data; the ADC changes it on the falling edge of `ad_sclk`.
- sample  out  8  last captured sample, registered; feeds the chain `datain`.
- sample_valid  out  1  one-cycle pulse when `sample` updates.
- busy  out  1  high while a conversion is in progress.
- overrun  out  1  sticky flag: a start request was dropped because the block was busy.

## Operation

- Period timer
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - Held at 0 while `enable` is low.
  - A start request occurs when `enable`=1 and timer=0.
  - The first request therefore happens on the first cycle `enable` is sampled high.
- State machine states: IDLE, SETUP, SHIFT, DONE.
- IDLE
  - `ad_cs_n`=1, `ad_sclk`=0.
  - On a start request, go to SETUP.
- SETUP
  - `ad_cs_n`=0, `ad_sclk`=0.
  - Lasts 2*CLK_DIV cycles, then go to SHIFT with bit index 7.
- SHIFT
  - 8 bit periods of 2*CLK_DIV cycles each.
  - Phase counter k runs 0..2*CLK_DIV-1; `ad_sclk`=0 for k<CLK_DIV and 1 otherwise.
  - `ad_dout` is captured into the shift register at the clock edge where `ad_sclk` goes 0->1 (k=CLK_DIV).
  - Bits arrive MSB first.
  - After the bit-0 period ends, go to DONE.
- DONE
  - Lasts one cycle.
  - `ad_cs_n`=1, `ad_sclk`=0.
  - `sample` is loaded from the shift register and `sample_valid`=1.
  - Then go to IDLE.
- `busy`=1 in SETUP, SHIFT and DONE.
- A start request that arrives while `busy`=1 is dropped and sets `overrun`=1. `overrun` clears only on reset.
- `enable` falling mid-conversion: the conversion completes normally, no further starts occur, and the timer returns to 0.
- `sample` holds its value between conversions.

## Timing

- Reset values (asserted asynchronously and immediately):
  - `ad_cs_n`=1, `ad_sclk`=0, `sample`=0x00.
  - `sample_valid`=0, `busy`=0, `overrun`=0.
  - State IDLE, timer 0, shift register 0.
- Reset mid-conversion aborts it: no `sample_valid` pulse and `sample` is unchanged from 0.
- All outputs are registered. Let a start request be sampled at edge n:
  - `ad_cs_n` falls and `busy` rises after edge n, visible in cycle n+1.
  - The first `ad_sclk` rise is at cycle n+1+2*CLK_DIV+CLK_DIV.
  - `sample_valid` is high in cycle n+1+18*CLK_DIV only (n+73 for CLK_DIV=4).
  - `ad_cs_n` returns high and `busy` drops in the cycle after DONE.
- Conversion length is 18*CLK_DIV+1 cycles.
  - If SAMPLE_PERIOD > 18*CLK_DIV+1, no overrun can occur.
  - If SAMPLE_PERIOD is smaller, every colliding request is dropped.
- Consecutive `sample_valid` pulses are exactly SAMPLE_PERIOD cycles apart in steady state.
- Simultaneous start request and DONE: the request is dropped because `busy`=1, and `overrun` is set.

## Test plan

- Defaults; ADC model shifts 0xA5 MSB first on `ad_sclk` falling edges; raise `enable` at cycle 0 -> `ad_cs_n` low at cycle 1, `sample`=0xA5 with a single `sample_valid` pulse at cycle 73, `busy` low at cycle 74.
- Defaults, `enable` held high, model returns 0x00, 0xFF, 0x3C -> valid pulses at cycles 73, 329, 585 carrying 0x00, 0xFF, 0x3C; exactly 8 `ad_sclk` rises per conversion; `overrun` stays 0.
- Assert `reset` during SHIFT (cycle 40) -> all outputs immediately take their reset values, no valid pulse occurs, and after release with `enable` high the next conversion captures correctly.
- CLK_DIV=4, SAMPLE_PERIOD=50, `enable` high -> `overrun`=1 at the first collided request; conversions still yield correct samples; `overrun` stays 1 until reset.
- Drop `enable` at cycle 20 -> the conversion completes with a valid pulse at cycle 73, and there is no further `ad_cs_n` activity for 1000 cycles.
- CLK_DIV=1, model drives 0x81 -> `ad_sclk` period is 2 cycles, valid pulse at cycle 19 with `sample`=0x81.
